// File: rtl/sig_dump_pkg.sv
// +--------------------------------------------------------------------------+
// | sig_dump_pkg                                                             |
// | Shared state encoding and default magic addresses for sig_dump_ctrl.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sig_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        CKS  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [31:0] C_SIG_BEGIN_ADDR = 32'h0000_0508;
    localparam logic [31:0] C_SIG_END_ADDR   = 32'h0000_050c;
    localparam logic [31:0] C_HALT_ADDR      = 32'h0000_0600;
    localparam logic [31:0] C_DRAM_BASE      = 32'h4000_0000;
    localparam int          C_DRAM_AW        = 12;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sig_dump_ctrl.sv
// +--------------------------------------------------------------------------+
// | sig_dump_ctrl                                                            |
// | Snoops signature begin/end/halt writes, then streams the DRAM signature  |
// | window on a valid/ready port. Define SIG_CHECKSUM_EN to append a         |
// | 32-bit wrapping checksum word after the data.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sig_dump_ctrl
    import sig_dump_pkg::*;
#(
    parameter logic [31:0] SIG_BEGIN_ADDR = C_SIG_BEGIN_ADDR,
    parameter logic [31:0] SIG_END_ADDR   = C_SIG_END_ADDR,
    parameter logic [31:0] HALT_ADDR      = C_HALT_ADDR,
    parameter logic [31:0] DRAM_BASE      = C_DRAM_BASE,
    parameter int          DRAM_AW        = C_DRAM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dram_we,
    input  logic [31:0]        dram_addr,
    input  logic [31:0]        dram_wdat,
    output logic               core_halt,
    output logic               rd_en,
    output logic [DRAM_AW-1:0] rd_addr,
    input  logic [31:0]        rd_dat,
    output logic               sig_valid,
    output logic [31:0]        sig_data,
    input  logic               sig_ready,
    output logic               sig_last,
    output logic               dump_done
);

    state_t      r_state;
    logic [31:0] r_beg;
    logic [31:0] r_end;
    logic [31:0] r_ptr;
    logic        r_final;
`ifdef SIG_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_cks_word;
`endif

    logic        w_begin_hit;
    logic        w_end_hit;
    logic        w_halt_hit;
    logic [32:0] w_ptr_inc;
    logic        w_last;
    logic [31:0] w_rd_src;
    logic [31:0] w_rd_off;
    logic        w_unused_bits;

    assign w_begin_hit = dram_we && (dram_addr == SIG_BEGIN_ADDR);
    assign w_end_hit   = dram_we && (dram_addr == SIG_END_ADDR);
    assign w_halt_hit  = dram_we && (dram_addr == HALT_ADDR);

    // A carry out of ptr+4 means the address space wrapped: treat as last.
    assign w_ptr_inc = {1'b0, r_ptr} + 33'd4;
    assign w_last    = w_ptr_inc[32] || (w_ptr_inc[31:0] >= r_end);

    // The next read address is either the window start or the advanced pointer.
    assign w_rd_src = (r_state == IDLE) ? r_beg : w_ptr_inc[31:0];
    assign w_rd_off = w_rd_src - DRAM_BASE;

    assign w_unused_bits = ^{w_rd_off[31:DRAM_AW+2], w_rd_off[1:0], dram_wdat[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beg      <= '0;
            r_end      <= '0;
            r_ptr      <= '0;
            r_final    <= 1'b0;
            core_halt  <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            sig_valid  <= 1'b0;
            sig_data   <= '0;
            sig_last   <= 1'b0;
            dump_done  <= 1'b0;
`ifdef SIG_CHECKSUM_EN
            r_sum      <= '0;
            r_cks_word <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_begin_hit) begin
                        r_beg <= word_align(dram_wdat);
                    end
                    if (w_end_hit) begin
                        r_end <= word_align(dram_wdat);
                    end
                    if (w_halt_hit) begin
                        core_halt <= 1'b1;
                        r_ptr     <= r_beg;
`ifdef SIG_CHECKSUM_EN
                        r_sum      <= '0;
                        r_cks_word <= 1'b0;
`endif
                        if (r_end <= r_beg) begin
`ifdef SIG_CHECKSUM_EN
                            r_state   <= CKS;
`else
                            r_state   <= DONE;
                            dump_done <= 1'b1;
`endif
                        end else begin
                            r_state <= RD;
                            rd_en   <= 1'b1;
                            rd_addr <= w_rd_off[DRAM_AW+1:2];
                        end
                    end
                end

                RD: begin
                    rd_en   <= 1'b0;
                    r_state <= WAIT;
                end

                WAIT: begin
                    sig_data  <= rd_dat;
                    sig_valid <= 1'b1;
                    r_final   <= w_last;
`ifdef SIG_CHECKSUM_EN
                    sig_last  <= 1'b0;
                    r_sum     <= r_sum + rd_dat;
`else
                    sig_last  <= w_last;
`endif
                    r_state   <= OUT;
                end

                OUT: begin
                    if (sig_ready) begin
                        sig_valid <= 1'b0;
                        r_ptr     <= w_ptr_inc[31:0];
`ifdef SIG_CHECKSUM_EN
                        if (r_cks_word) begin
                            r_state   <= DONE;
                            dump_done <= 1'b1;
                        end else if (r_final) begin
                            r_state <= CKS;
                        end else begin
                            r_state <= RD;
                            rd_en   <= 1'b1;
                            rd_addr <= w_rd_off[DRAM_AW+1:2];
                        end
`else
                        if (r_final) begin
                            r_state   <= DONE;
                            dump_done <= 1'b1;
                        end else begin
                            r_state <= RD;
                            rd_en   <= 1'b1;
                            rd_addr <= w_rd_off[DRAM_AW+1:2];
                        end
`endif
                    end
                end

`ifdef SIG_CHECKSUM_EN
                CKS: begin
                    sig_data   <= r_sum;
                    sig_valid  <= 1'b1;
                    sig_last   <= 1'b1;
                    r_cks_word <= 1'b1;
                    r_state    <= OUT;
                end
`endif

                DONE: begin
                    core_halt <= 1'b1;
                    dump_done <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
